// File: rtl/fdiv_multi_if.sv
// fdiv_multi_if: control/status bundle for the multi-channel frequency divider.
//   load/load_ch/div_in/high_in/auto_in : shadow-register write port
//   en                                  : per-channel count enable
//   resync                              : restart all channels in phase
//   fout/tc/pend                        : divided clocks, wrap pulses, shadow-pending flags
interface fdiv_multi_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int CHW   = 2
);
    logic             load;
    logic [CHW-1:0]   load_ch;
    logic [WIDTH-1:0] div_in;
    logic [WIDTH-1:0] high_in;
    logic             auto_in;
    logic [NCH-1:0]   en;
    logic             resync;
    logic [NCH-1:0]   fout;
    logic [NCH-1:0]   tc;
    logic [NCH-1:0]   pend;

    modport master (
        output load, load_ch, div_in, high_in, auto_in, en, resync,
        input  fout, tc, pend
    );

    modport slave (
        input  load, load_ch, div_in, high_in, auto_in, en, resync,
        output fout, tc, pend
    );
endinterface

// File: rtl/fdiv_multi.sv
// fdiv_multi: NCH independent programmable dividers of the clock fin.
//   fin    : input clock, all state updates on its rising edge
//   reset  : synchronous active-high reset, returns every channel to stopped
//   bus    : fdiv_multi_if slave modport (load port, enables, resync, outputs)
// Each channel counts 1..div_act; fout is high while the pre-edge count is above
// div_act - heff. New settings sit in a shadow until a wrap, a stopped channel
// or resync lets them take effect, so the divisor never changes mid-period.
module fdiv_multi #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int CHW   = 2
) (
    input  logic         fin,
    input  logic         reset,
    fdiv_multi_if.slave  bus
);
    logic [WIDTH-1:0] cnt      [NCH];
    logic [WIDTH-1:0] div_act  [NCH];
    logic [WIDTH-1:0] high_act [NCH];
    logic [WIDTH-1:0] div_sh   [NCH];
    logic [WIDTH-1:0] high_sh  [NCH];
    logic [WIDTH-1:0] heff     [NCH];
    logic [WIDTH-1:0] thr      [NCH];
    logic [NCH-1:0]   auto_act, auto_sh;
    logic [NCH-1:0]   pend_q, fout_q, tc_q;
    logic [NCH-1:0]   wrap, ld_hit, apply;

    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            if (auto_act[c])
                heff[c] = div_act[c] - (div_act[c] >> 1);
            else
                heff[c] = (high_act[c] < div_act[c]) ? high_act[c] : div_act[c];
            thr[c]    = div_act[c] - heff[c];
            wrap[c]   = (cnt[c] >= div_act[c]);
            // load_ch values >= NCH never match any channel index
            ld_hit[c] = bus.load && (bus.load_ch == CHW'(c));
            apply[c]  = bus.resync || (div_act[c] == '0) || (bus.en[c] && wrap[c]);
        end
    end

    always_ff @(posedge fin) begin
        if (reset) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                cnt[c]      <= WIDTH'(1);
                div_act[c]  <= '0;
                high_act[c] <= '0;
                div_sh[c]   <= '0;
                high_sh[c]  <= '0;
            end
            auto_act <= '0;
            auto_sh  <= '0;
            pend_q   <= '0;
            fout_q   <= '0;
            tc_q     <= '0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                // Output/counter path always uses the pre-edge (old) parameters.
                if (bus.resync || (div_act[c] == '0)) begin
                    cnt[c]    <= WIDTH'(1);
                    fout_q[c] <= 1'b0;
                    tc_q[c]   <= 1'b0;
                end else if (bus.en[c]) begin
                    cnt[c]    <= wrap[c] ? WIDTH'(1) : cnt[c] + WIDTH'(1);
                    fout_q[c] <= (cnt[c] > thr[c]);
                    tc_q[c]   <= wrap[c];
                end else begin
                    tc_q[c]   <= 1'b0;
                end

                if (ld_hit[c]) begin
                    div_sh[c]  <= bus.div_in;
                    high_sh[c] <= bus.high_in;
                    auto_sh[c] <= bus.auto_in;
                end

                // A load landing on an apply edge skips the shadow entirely.
                if (apply[c]) begin
                    if (ld_hit[c]) begin
                        div_act[c]  <= bus.div_in;
                        high_act[c] <= bus.high_in;
                        auto_act[c] <= bus.auto_in;
                    end else if (pend_q[c]) begin
                        div_act[c]  <= div_sh[c];
                        high_act[c] <= high_sh[c];
                        auto_act[c] <= auto_sh[c];
                    end
                    pend_q[c] <= 1'b0;
                end else if (ld_hit[c]) begin
                    pend_q[c] <= 1'b1;
                end
            end
        end
    end

    assign bus.fout = fout_q;
    assign bus.tc   = tc_q;
    assign bus.pend = pend_q;
endmodule

// File: tb/tb_fdiv_multi.sv
// tb_fdiv_multi: directed stimulus for fdiv_multi with a queue-based scoreboard.
// The stimulus pushes the hand-derived expected fout/tc/pend for every edge it
// issues; an independent monitor pops and compares after each rising edge.
module tb_fdiv_multi;
    typedef struct {
        logic [3:0] m;   // channel mask for fout/tc
        logic [3:0] f;
        logic [3:0] t;
        logic [3:0] pm;  // channel mask for pend
        logic [3:0] p;
        string      nm;
    } exp_t;

    logic fin;
    logic reset;
    int   checks;
    int   failures;
    exp_t q[$];

    fdiv_multi_if #(.WIDTH(32), .NCH(4), .CHW(2)) bus ();

    fdiv_multi #(.WIDTH(32), .NCH(4), .CHW(2)) dut (
        .fin   (fin),
        .reset (reset),
        .bus   (bus)
    );

    initial fin = 1'b0;
    always #5 fin = ~fin;

    // Monitor: one expectation record per rising edge, compared 2 time units later.
    initial begin
        exp_t r;
        forever begin
            @(posedge fin);
            #2;
            if (q.size() > 0) begin
                r = q.pop_front();
                if (r.m != 4'b0) begin
                    checks++;
                    if ((bus.fout & r.m) !== (r.f & r.m)) begin
                        failures++;
                        $display("FAIL %s fout: got %b want %b (mask %b)", r.nm, bus.fout, r.f, r.m);
                    end
                    checks++;
                    if ((bus.tc & r.m) !== (r.t & r.m)) begin
                        failures++;
                        $display("FAIL %s tc: got %b want %b (mask %b)", r.nm, bus.tc, r.t, r.m);
                    end
                end
                if (r.pm != 4'b0) begin
                    checks++;
                    if ((bus.pend & r.pm) !== (r.p & r.pm)) begin
                        failures++;
                        $display("FAIL %s pend: got %b want %b (mask %b)", r.nm, bus.pend, r.p, r.pm);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc(input logic [3:0] m, input logic [3:0] f, input logic [3:0] t,
                       input logic [3:0] pm, input logic [3:0] p, input string nm);
        exp_t r;
        r.m = m; r.f = f; r.t = t; r.pm = pm; r.p = p; r.nm = nm;
        q.push_back(r);
        @(posedge fin);
        @(negedge fin);
        bus.load   = 1'b0;
        bus.resync = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic lset(input logic [1:0] ch, input int unsigned n, input int unsigned h, input logic a);
        bus.load    = 1'b1;
        bus.load_ch = ch;
        bus.div_in  = n;
        bus.high_in = h;
        bus.auto_in = a;
    endtask

    initial begin
        logic f, t, f2, t2;
        checks   = 0;
        failures = 0;
        reset       = 1'b1;
        bus.load    = 1'b0;
        bus.load_ch = '0;
        bus.div_in  = '0;
        bus.high_in = '0;
        bus.auto_in = 1'b0;
        bus.en      = '0;
        bus.resync  = 1'b0;
        @(negedge fin);

        // Reset state
        reset = 1'b1;
        cyc(4'hF, 4'h0, 4'h0, 4'hF, 4'h0, "reset");

        // ch0 N=5 auto: loading a stopped channel applies immediately
        bus.en = 4'b0001;
        lset(2'd0, 5, 0, 1'b1);
        cyc(4'h1, 4'h0, 4'h0, 4'h1, 4'h0, "ch0_ld_bypass");
        for (int k = 1; k <= 10; k++) begin
            f = ((k - 1) % 5) >= 2;
            t = (k % 5) == 0;
            cyc(4'h1, {3'b0, f}, {3'b0, t}, 4'h1, 4'h0, "ch0_n5");
        end

        // Mid-period load N=3: old period finishes, pend held until the wrap
        cyc(4'h1, 4'h0, 4'h0, 4'h1, 4'h0, "ch0_pre1");
        cyc(4'h1, 4'h0, 4'h0, 4'h1, 4'h0, "ch0_pre2");
        lset(2'd0, 3, 0, 1'b1);
        cyc(4'h1, 4'h1, 4'h0, 4'h1, 4'h1, "ch0_ld_mid");
        cyc(4'h1, 4'h1, 4'h0, 4'h1, 4'h1, "ch0_old_c4");
        cyc(4'h1, 4'h1, 4'h1, 4'h1, 4'h0, "ch0_apply_wrap");
        for (int k = 1; k <= 6; k++) begin
            f = (k % 3) != 1;
            t = (k % 3) == 0;
            cyc(4'h1, {3'b0, f}, {3'b0, t}, 4'h1, 4'h0, "ch0_n3");
        end

        // ch1 N=4 high=1, then high=7 clamps to 4
        bus.en = 4'b0011;
        lset(2'd1, 4, 1, 1'b0);
        cyc(4'h2, 4'h0, 4'h0, 4'h2, 4'h0, "ch1_ld_bypass");
        for (int k = 1; k <= 8; k++) begin
            f = (k % 4) == 0;
            cyc(4'h2, {2'b0, f, 1'b0}, {2'b0, f, 1'b0}, 4'h2, 4'h0, "ch1_h1");
        end
        lset(2'd1, 4, 7, 1'b0);
        cyc(4'h2, 4'h0, 4'h0, 4'h2, 4'h2, "ch1_ld_h7");
        cyc(4'h2, 4'h0, 4'h0, 4'h2, 4'h2, "ch1_pend_c2");
        cyc(4'h2, 4'h0, 4'h0, 4'h2, 4'h2, "ch1_pend_c3");
        cyc(4'h2, 4'h2, 4'h2, 4'h2, 4'h0, "ch1_apply");
        for (int k = 1; k <= 8; k++) begin
            t = (k % 4) == 0;
            cyc(4'h2, 4'h2, {2'b0, t, 1'b0}, 4'h2, 4'h0, "ch1_clamped");
        end

        // Resync of ch0 (N=5) and ch2 (N=3) running out of phase
        reset = 1'b1;
        cyc(4'hF, 4'h0, 4'h0, 4'hF, 4'h0, "reset2");
        bus.en = 4'b0101;
        lset(2'd0, 5, 0, 1'b1);
        cyc(4'h1, 4'h0, 4'h0, 4'h1, 4'h0, "rs_ld0");
        lset(2'd2, 3, 0, 1'b1);
        cyc(4'h5, 4'h0, 4'h0, 4'h5, 4'h0, "rs_ld2");
        cyc(4'h5, 4'h0, 4'h0, 4'h0, 4'h0, "rs_skew1");
        cyc(4'h5, 4'h5, 4'h0, 4'h0, 4'h0, "rs_skew2");
        bus.resync = 1'b1;
        cyc(4'h5, 4'h0, 4'h0, 4'h5, 4'h0, "resync");
        for (int k = 1; k <= 15; k++) begin
            f  = ((k - 1) % 5) >= 2;
            t  = (k % 5) == 0;
            f2 = (k % 3) != 1;
            t2 = (k % 3) == 0;
            cyc(4'h5, {1'b0, f2, 1'b0, f}, {1'b0, t2, 1'b0, t}, 4'h0, 4'h0, "rs_inphase");
        end

        // en[0] dropped for 3 cycles while fout[0] is high
        cyc(4'h1, 4'h0, 4'h0, 4'h0, 4'h0, "en_c1");
        cyc(4'h1, 4'h0, 4'h0, 4'h0, 4'h0, "en_c2");
        cyc(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, "en_c3");
        bus.en = 4'b0100;
        for (int k = 1; k <= 3; k++)
            cyc(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, "en_frozen");
        bus.en = 4'b0101;
        cyc(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, "en_resume_c4");
        cyc(4'h1, 4'h1, 4'h1, 4'h0, 4'h0, "en_resume_c5");
        cyc(4'h1, 4'h0, 4'h0, 4'h0, 4'h0, "en_next_c1");

        // N=0 applies at the wrap and stops the channel; N=2 then applies at once
        lset(2'd0, 0, 0, 1'b0);
        cyc(4'h1, 4'h0, 4'h0, 4'h1, 4'h1, "n0_ld");
        cyc(4'h1, 4'h1, 4'h0, 4'h1, 4'h1, "n0_c3");
        cyc(4'h1, 4'h1, 4'h0, 4'h1, 4'h1, "n0_c4");
        cyc(4'h1, 4'h1, 4'h1, 4'h1, 4'h0, "n0_apply");
        for (int k = 1; k <= 3; k++)
            cyc(4'h1, 4'h0, 4'h0, 4'h1, 4'h0, "n0_stopped");
        lset(2'd0, 2, 0, 1'b1);
        cyc(4'h1, 4'h0, 4'h0, 4'h1, 4'h0, "n2_immediate");
        for (int k = 1; k <= 4; k++) begin
            f = (k % 2) == 0;
            cyc(4'h1, {3'b0, f}, {3'b0, f}, 4'h1, 4'h0, "n2_run");
        end

        // Reset mid-period
        reset = 1'b1;
        cyc(4'hF, 4'h0, 4'h0, 4'hF, 4'h0, "reset_mid");
        cyc(4'hF, 4'h0, 4'h0, 4'hF, 4'h0, "post_reset");

        // N=1 boundary: heff=0 gives fout 0 and tc every edge; load on a wrap bypasses
        bus.en = 4'b1000;
        lset(2'd3, 1, 0, 1'b0);
        cyc(4'h8, 4'h0, 4'h0, 4'h8, 4'h0, "n1_ld");
        for (int k = 1; k <= 3; k++)
            cyc(4'h8, 4'h0, 4'h8, 4'h8, 4'h0, "n1_h0");
        lset(2'd3, 1, 1, 1'b0);
        cyc(4'h8, 4'h0, 4'h8, 4'h8, 4'h0, "n1_ld_on_wrap");
        cyc(4'h8, 4'h8, 4'h8, 4'h8, 4'h0, "n1_h1");
        cyc(4'h8, 4'h8, 4'h8, 4'h8, 4'h0, "n1_h1b");

        // Every expectation must have been consumed by the monitor
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
